// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both slave and master blocks.
//   spi_state_e  : transfer state (idle / active)
//   DefaultWidth : default transfer word length in bits
//   Cpol, Cpha   : supported SPI mode (mode 0 only)
package spi_pkg;

    typedef enum logic {
        StIdle,
        StActive
    } spi_state_e;

    localparam int unsigned DefaultWidth = 8;

    localparam logic Cpol = 1'b0;
    localparam logic Cpha = 1'b0;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk_i : destination clock
//   rst_i : synchronous active-high reset, loads ResetVal into both flops
//   d_i   : asynchronous input
//   q_o   : synchronized output
module spi_sync #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, mode 0 (CPOL=0, CPHA=0), MSB first, oversampled by clk_i.
//   clk_i     : system clock (>= 4x sclk)
//   rst_i     : synchronous active-high reset
//   sclk_i    : SPI clock from master (asynchronous)
//   ss_i      : slave select, active-low (asynchronous)
//   mosi_i    : serial data from master (asynchronous)
//   miso_o    : serial data to master, 0 when not selected
//   up_data_i : one-cycle strobe, loads data_i into the TX buffer
//   data_i    : word to transmit
//   s_data_o  : last completely received word
//   s_valid_o : one-cycle pulse when s_data_o updates
//   busy_o    : high while selected
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned Width = DefaultWidth
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sclk_i,
    input  logic             ss_i,
    input  logic             mosi_i,
    output logic             miso_o,
    input  logic             up_data_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] s_data_o,
    output logic             s_valid_o,
    output logic             busy_o
);

    localparam int unsigned CntW = $clog2(Width);
    localparam logic [CntW-1:0] LastBit = CntW'(Width - 1);

    logic sclk_s;
    logic ss_s;
    logic mosi_s;

    spi_sync #(.ResetVal(1'b0)) u_sync_sclk (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (sclk_i),
        .q_o   (sclk_s)
    );

    spi_sync #(.ResetVal(1'b1)) u_sync_ss (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (ss_i),
        .q_o   (ss_s)
    );

    spi_sync #(.ResetVal(1'b0)) u_sync_mosi (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (mosi_i),
        .q_o   (mosi_s)
    );

    spi_state_e       state_q, state_d;
    logic [Width-1:0] tx_buf_q, tx_buf_d;
    logic [Width-1:0] tx_shift_q, tx_shift_d;
    logic [Width-1:0] rx_shift_q, rx_shift_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [Width-1:0] s_data_q, s_data_d;
    logic             s_valid_q, s_valid_d;
    logic             sclk_prev_q;
    logic             ss_prev_q, ss_prev_d;
    logic [1:0]       flush_q, flush_d;

    logic             flushed;
    logic             sclk_rise;
    logic             sclk_fall;
    logic             ss_fall;
    logic [Width-1:0] rx_next;

    // The synchronizers hold their idle levels for two cycles after reset.
    // ss_prev_q is held low until real samples arrive, so an ss that was
    // already low at reset release never looks like a falling edge.
    assign flushed   = (flush_q == 2'd2);
    assign flush_d   = flushed ? flush_q : flush_q + 2'd1;
    assign ss_prev_d = flushed ? ss_s : 1'b0;

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;
    assign rx_next   = {rx_shift_q[Width-2:0], mosi_s};

    always_comb begin
        state_d    = state_q;
        tx_buf_d   = up_data_i ? data_i : tx_buf_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        s_data_d   = s_data_q;
        s_valid_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ss_fall) begin
                    state_d    = StActive;
                    tx_shift_d = tx_buf_q;
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            StActive: begin
                if (ss_s) begin
                    // Deselect aborts any partial word.
                    state_d    = StIdle;
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_next;
                    if (bit_cnt_q == LastBit) begin
                        s_data_d  = rx_next;
                        s_valid_d = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end else if (sclk_fall) begin
                    // bit_cnt_q == 0 here means the previous word just completed.
                    if (bit_cnt_q == '0) begin
                        tx_shift_d = tx_buf_q;
                    end else begin
                        tx_shift_d = {tx_shift_q[Width-2:0], 1'b0};
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            tx_buf_q    <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            s_data_q    <= '0;
            s_valid_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
            flush_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            tx_buf_q    <= tx_buf_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            s_data_q    <= s_data_d;
            s_valid_q   <= s_valid_d;
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_prev_d;
            flush_q     <= flush_d;
        end
    end

    assign busy_o    = (state_q == StActive);
    assign miso_o    = busy_o ? tx_shift_q[Width-1] : 1'b0;
    assign s_data_o  = s_data_q;
    assign s_valid_o = s_valid_q;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: width, 8, transfer word length in bits (>= 2).
REQ-002 Port: clk  input  1  system clock, single clock domain.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: sclk  input  1  SPI serial clock from master, asynchronous to clk.
REQ-005 Port: ss  input  1  slave select from master, active-low, asynchronous.
REQ-006 Port: mosi  input  1  serial data from master, asynchronous.
REQ-007 Port: miso  output  1  serial data to master.
REQ-008 Port: up_data  input  1  one-cycle strobe; loads data into TX buffer.
REQ-009 Port: data  input  width  word to transmit.
REQ-010 Port: s_data  output  width  last completely received word.
REQ-011 Port: s_valid  output  1  one-cycle pulse when s_data updates.
REQ-012 Port: busy  output  1  high while a transfer is selected (state ACTIVE).

Function
REQ-013 SPI mode 0 only (CPOL=0, CPHA=0), MSB first: sample mosi on sclk rising, shift miso on sclk falling.
REQ-014 sclk, ss, mosi each pass through a 2-flop synchronizer; all edges detected on synchronized values; clk SHALL be >= 4x sclk frequency.
REQ-015 FSM states: IDLE, ACTIVE. IDLE->ACTIVE on synchronized ss falling; ACTIVE->IDLE on synchronized ss rising.
REQ-016 On IDLE->ACTIVE: tx_shift <= tx_buf, bit_cnt <= 0; miso drives tx_shift[width-1] from the same cycle.
REQ-017 miso = tx_shift[width-1] in ACTIVE, 0 in IDLE (no tristate; top muxes slaves).
REQ-018 On synchronized sclk rising in ACTIVE: rx_shift <= {rx_shift[width-2:0], mosi_sync}; bit_cnt increments.
REQ-019 When the rising edge is bit width-1: s_data <= {rx_shift[width-2:0], mosi_sync}, s_valid = 1 next cycle for exactly one cycle, bit_cnt wraps to 0.
REQ-020 On synchronized sclk falling in ACTIVE: if bit_cnt == 0 (word boundary), tx_shift <= tx_buf; else tx_shift shifts left by one with 0 fill.
REQ-021 Back-to-back words with ss held low SHALL be received/transmitted without gaps; each word raises its own s_valid.
REQ-022 up_data: tx_buf <= data next cycle; during ACTIVE the new word takes effect at the next word boundary only, never mid-word.
REQ-023 ss deasserted mid-word: abort, bit_cnt <= 0, no s_valid, s_data unchanged, partial rx discarded, return IDLE.
REQ-024 up_data coincident with word-boundary load: the boundary loads the old tx_buf; new value used at the following boundary.
REQ-025 Latency: s_valid rises at most 4 clk cycles after the raw width-th sclk rising edge.

Reset
REQ-026 rst synchronous, active-high, dominates all other inputs, including mid-transfer.
REQ-027 Reset values: state IDLE, s_data 0, s_valid 0, busy 0, miso 0, tx_buf 0, tx_shift 0, rx_shift 0, bit_cnt 0, synchronizer flops to idle levels (sclk 0, ss 1, mosi 0).
REQ-028 After rst release with ss already low, no transfer starts until a fresh ss falling edge is seen.

Structure
REQ-029 Package spi_pkg holds: state enum (IDLE, ACTIVE), default width constant, mode constants (CPOL/CPHA = 0), shared with the SPI master.
REQ-030 One sub-module spi_sync (2-flop synchronizer, parameterized reset value), instantiated for sclk, ss, mosi.
REQ-031 bit_cnt width = $clog2(width).

Verification
REQ-032 Reset: hold rst 4 cycles with sclk toggling -> all outputs 0, busy 0, no s_valid.
REQ-033 Single word: up_data with data=0xA5, master sends 0x3C -> s_data=0x3C, one s_valid pulse, miso bits 1,0,1,0,0,1,0,1.
REQ-034 Back-to-back: tx_buf=0x81, master sends 0x12 then 0x34 under one ss -> s_valid twice, s_data 0x12 then 0x34, miso 0x81 twice.
REQ-035 Abort: ss rises after 5 bits of 0xFF -> no s_valid, s_data keeps prior value, busy falls, next full word received correctly.
REQ-036 Mid-word update: up_data 0x55 during bit 3 of a word sending 0xF0 -> current miso word stays 0xF0, next word 0x55.
REQ-037 Reset mid-transfer: rst after 4 bits -> outputs at reset values; following ss cycle with 0x99 -> s_data=0x99.
